// File: rtl/tx_pkg.sv
// Shared definitions for the TX burst sequencer.
//   tx_seq_state_t : sequencer state encoding. PREAMBLE is present only when
//                    TX_SEQ_PREAMBLE_EN is defined.
//   PHASE_W        : width of the sample-phase counter and the o_phase port.
//   *_DEF          : default values for the sequencer parameters.
package tx_pkg;

  localparam int unsigned PHASE_W          = 3;
  localparam int unsigned OS_FACTOR_DEF    = 4;
  localparam int unsigned PREAMBLE_LEN_DEF = 8;
  localparam int unsigned FLUSH_CYC_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEED     = 3'd1,
`ifdef TX_SEQ_PREAMBLE_EN
    PREAMBLE = 3'd2,
`endif
    RUN      = 3'd3,
    FLUSH    = 3'd4
  } tx_seq_state_t;

endpackage

// File: rtl/tx_sequencer_sym_timer.sv
// Symbol timer: sample-phase counter with symbol start/end strobes.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset, phase -> 0
//   enable    : advance the phase one step per clock
//   clear     : hold the phase at 0 (takes priority over enable)
//   phase     : current sample phase, 0..OS_FACTOR-1
//   sym_start : enable && phase == 0 (first sample of a symbol)
//   sym_last  : enable && phase == OS_FACTOR-1 (last sample of a symbol)
module sym_timer
  import tx_pkg::*;
#(
  parameter int unsigned OS_FACTOR = OS_FACTOR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  output logic [PHASE_W-1:0] phase,
  output logic               sym_start,
  output logic               sym_last
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OS_FACTOR - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    end
  end

  assign sym_start = enable && (phase == '0);
  assign sym_last  = enable && (phase == PHASE_LAST);

endmodule

// File: rtl/tx_sequencer.sv
// TX burst sequencer: drives the PRBS generator and the upconverter symbol
// strobe through SEED, optional PREAMBLE, RUN and FLUSH phases of a burst.
// Optional feature macro: TX_SEQ_PREAMBLE_EN (adds the PREAMBLE state and the
// PREAMBLE_LEN parameter; without it o_preamble is tied low).
// Ports:
//   clock          : rising-edge clock
//   i_reset        : synchronous active-high reset
//   i_start        : level request to start a burst (sampled in IDLE only)
//   i_stop         : level request to abort a burst (wins over i_start)
//   i_burst_len    : payload symbols in the burst
//   o_busy         : state is not IDLE
//   o_done         : one-clock pulse on the first IDLE cycle after FLUSH
//   o_prbs_reset   : PRBS seed/reset
//   o_prbs_enable  : PRBS advance, one per payload symbol
//   o_sym_valid    : symbol strobe
//   o_phase        : sample phase within the symbol
//   o_preamble     : marks preamble symbols
module tx_sequencer
  import tx_pkg::*;
#(
  parameter int unsigned OS_FACTOR    = OS_FACTOR_DEF,
  parameter int unsigned BURST_W      = 16,
`ifdef TX_SEQ_PREAMBLE_EN
  parameter int unsigned PREAMBLE_LEN = PREAMBLE_LEN_DEF,
`endif
  parameter int unsigned FLUSH_CYC    = FLUSH_CYC_DEF
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_prbs_reset,
  output logic               o_prbs_enable,
  output logic               o_sym_valid,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_preamble
);

  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYC + 1);
`ifdef TX_SEQ_PREAMBLE_EN
  localparam int unsigned PRE_W   = $clog2(PREAMBLE_LEN + 1);
`endif

  tx_seq_state_t      state;
  logic [BURST_W-1:0] sym_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
`ifdef TX_SEQ_PREAMBLE_EN
  logic [PRE_W-1:0]   pre_cnt;
`endif
  logic               stop_latch;
  logic               done_pend;

  logic               sym_active;
  logic               stop_req;
  logic [PHASE_W-1:0] phase;
  logic               sym_start;
  logic               sym_last;

`ifdef TX_SEQ_PREAMBLE_EN
  assign sym_active = (state == PREAMBLE) || (state == RUN);
`else
  assign sym_active = (state == RUN);
`endif

  // A stop seen at any sample of a symbol is held until that symbol ends.
  assign stop_req = stop_latch || i_stop;

  sym_timer #(
    .OS_FACTOR (OS_FACTOR)
  ) u_sym_timer (
    .clock     (clock),
    .reset     (i_reset),
    .enable    (sym_active),
    .clear     (!sym_active),
    .phase     (phase),
    .sym_start (sym_start),
    .sym_last  (sym_last)
  );

`ifndef TX_SEQ_PREAMBLE_EN
  assign o_preamble = 1'b0;
`endif

  // Outputs are registered from the state held during the current clock, so
  // they appear one clock after the corresponding state is entered.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state         <= IDLE;
      sym_cnt       <= '0;
      flush_cnt     <= '0;
`ifdef TX_SEQ_PREAMBLE_EN
      pre_cnt       <= '0;
      o_preamble    <= 1'b0;
`endif
      stop_latch    <= 1'b0;
      done_pend     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_prbs_reset  <= 1'b1;
      o_prbs_enable <= 1'b0;
      o_sym_valid   <= 1'b0;
      o_phase       <= '0;
    end else begin
      o_busy        <= (state != IDLE);
      o_done        <= done_pend;
      o_prbs_reset  <= (state == SEED);
      o_prbs_enable <= sym_start && (state == RUN);
      o_sym_valid   <= sym_start;
      o_phase       <= phase;
`ifdef TX_SEQ_PREAMBLE_EN
      o_preamble    <= (state == PREAMBLE);
`endif
      done_pend     <= 1'b0;

      case (state)
        IDLE: begin
          stop_latch <= 1'b0;
          // Length is captured on the accepting edge so the value checked
          // for zero is the value that gets counted.
          if (i_start && !i_stop && (i_burst_len != '0)) begin
            sym_cnt <= i_burst_len;
            state   <= SEED;
          end
        end

        SEED: begin
          stop_latch <= 1'b0;
`ifdef TX_SEQ_PREAMBLE_EN
          pre_cnt    <= PRE_W'(PREAMBLE_LEN - 1);
          state      <= PREAMBLE;
`else
          state      <= RUN;
`endif
        end

`ifdef TX_SEQ_PREAMBLE_EN
        PREAMBLE: begin
          stop_latch <= stop_req;
          if (sym_last) begin
            if (stop_req) begin
              stop_latch <= 1'b0;
              flush_cnt  <= FLUSH_W'(FLUSH_CYC - 1);
              state      <= FLUSH;
            end else if (pre_cnt == '0) begin
              state <= RUN;
            end else begin
              pre_cnt <= pre_cnt - 1'b1;
            end
          end
        end
`endif

        RUN: begin
          stop_latch <= stop_req;
          if (sym_start && (sym_cnt != '0)) begin
            sym_cnt <= sym_cnt - 1'b1;
          end
          if (sym_last && (stop_req || (sym_cnt == '0))) begin
            stop_latch <= 1'b0;
            flush_cnt  <= FLUSH_W'(FLUSH_CYC - 1);
            state      <= FLUSH;
          end
        end

        FLUSH: begin
          stop_latch <= 1'b0;
          if (flush_cnt == '0) begin
            done_pend <= 1'b1;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer. The expected output trace of a burst
// is computed arithmetically from its symbol count and start cycle.
module tb_tx_sequencer;

  localparam int OS = 4;
  localparam int BW = 10;
  localparam int FL = 8;
`ifdef TX_SEQ_PREAMBLE_EN
  localparam int NPRE = 8;
`else
  localparam int NPRE = 0;
`endif

  // {busy, done, prbs_reset, prbs_enable, sym_valid, preamble, phase[2:0]}
  localparam logic [8:0] RST_VEC = 9'b001_000_000;

  logic          clock = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_stop;
  logic [BW-1:0] i_burst_len;
  logic          o_busy, o_done, o_prbs_reset, o_prbs_enable, o_sym_valid, o_preamble;
  logic [2:0]    o_phase;
  logic [8:0]    obs;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  tx_sequencer #(
    .OS_FACTOR (OS),
    .BURST_W   (BW),
    .FLUSH_CYC (FL)
  ) dut (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_burst_len   (i_burst_len),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_prbs_reset  (o_prbs_reset),
    .o_prbs_enable (o_prbs_enable),
    .o_sym_valid   (o_sym_valid),
    .o_phase       (o_phase),
    .o_preamble    (o_preamble)
  );

  assign obs = {o_busy, o_done, o_prbs_reset, o_prbs_enable, o_sym_valid, o_preamble, o_phase};

  // Expected outputs at cycle t (t=0 is the edge that samples i_start) of a
  // burst that emits m symbols in total, the first NPRE being preamble.
  function automatic logic [8:0] model(int t, int m);
    logic       busy, done, prst, pen, sv, pre;
    logic [2:0] ph;
    int         sym;
    busy = (t >= 1) && (t <= OS*m + FL + 1);
    done = (t == OS*m + FL + 2);
    prst = (t == 1);
    pen  = 1'b0;
    sv   = 1'b0;
    pre  = 1'b0;
    ph   = 3'd0;
    if (t >= 2 && t <= OS*m + 1) begin
      ph  = 3'((t - 2) % OS);
      sym = (t - 2) / OS;
      sv  = (ph == 3'd0);
      pre = (sym < NPRE);
      pen = sv && (sym >= NPRE);
    end
    return {busy, done, prst, pen, sv, pre, ph};
  endfunction

  task automatic check_vec(input string tag, input int t, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  // stop_e / rst_e: edge index at which i_stop / i_reset is high (-1: never).
  // noise: random i_start / i_burst_len while busy, which must be ignored.
  task automatic run_burst(input string tag, input int len, input int stop_e,
                           input int rst_e, input bit noise);
    int n, m, last, strobes, payload, exp_payload;
    logic [8:0] exp;
    n = NPRE + len;
    m = n;
    if (stop_e >= 2 && stop_e <= OS*n + 1) begin
      if ((stop_e + OS - 2) / OS < n) m = (stop_e + OS - 2) / OS;
    end
    last    = (rst_e >= 0) ? rst_e + 5 : OS*m + FL + 5;
    strobes = 0;
    payload = 0;
    for (int t = 0; t <= last; t++) begin
      i_start     = (t == 0);
      i_stop      = (t == stop_e);
      i_reset     = (t == rst_e);
      i_burst_len = (t <= 1) ? BW'(len) : '0;
      if (noise && t >= 2 && t <= OS*m + FL && (rst_e < 0 || t <= rst_e)) begin
        i_start     = 1'($urandom_range(0, 1));
        i_burst_len = BW'($urandom);
      end
      @(posedge clock);
      #1;
      if (rst_e >= 0 && t >= rst_e) exp = (t == rst_e) ? RST_VEC : 9'b0;
      else                          exp = model(t, m);
      check_vec(tag, t, exp);
      strobes += int'(o_sym_valid);
      payload += int'(o_prbs_enable);
    end
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_reset = 1'b0;
    if (rst_e < 0) begin
      exp_payload = (m > NPRE) ? m - NPRE : 0;
      check_int({tag, "_strobes"}, strobes, m);
      check_int({tag, "_payload"}, payload, exp_payload);
    end
  endtask

  // One request edge that must leave the sequencer idle.
  task automatic idle_request(input string tag, input bit start, input bit stop,
                              input int len);
    i_start     = start;
    i_stop      = stop;
    i_burst_len = BW'(len);
    for (int t = 0; t < 6; t++) begin
      @(posedge clock);
      #1;
      i_start = 1'b0;
      i_stop  = 1'b0;
      check_vec(tag, t, 9'b0);
    end
  endtask

  initial begin
    int len, stop_e;
    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_stop      = 1'b0;
    i_burst_len = '0;
    repeat (3) @(posedge clock);
    #1;
    check_vec("reset_values", 0, RST_VEC);
    i_reset = 1'b0;
    @(posedge clock);
    #1;
    check_vec("post_reset_idle", 0, 9'b0);

    run_burst("burst3", 3, -1, -1, 1'b0);
    run_burst("stop_at_8", 10, 8, -1, 1'b0);
    run_burst("stop_in_seed", 2, 1, -1, 1'b0);
    idle_request("zero_len", 1'b1, 1'b0, 0);
    idle_request("start_and_stop", 1'b1, 1'b1, 5);
    run_burst("reset_mid_burst", 10, -1, 20, 1'b0);
    run_burst("after_reset", 4, -1, -1, 1'b0);
    run_burst("len_one", 1, -1, -1, 1'b1);
    run_burst("max_len", (1 << BW) - 1, -1, -1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      len    = int'($urandom_range(1, 12));
      stop_e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, OS*(NPRE + len) + 3)) : -1;
      run_burst("random", len, stop_e, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_sequencer.md
TX_SEQUENCER -- requirements
Module: tx_sequencer

Interface
REQ-001 Parameter OS_FACTOR, default 4: clocks per symbol, legal range 2..8.
REQ-002 Parameter BURST_W, default 16: width of the burst-length field.
REQ-003 Parameter PREAMBLE_LEN, default 8: number of preamble symbols.
REQ-004 Parameter FLUSH_CYC, default 8: number of idle-output clocks after the last symbol.
REQ-005 Port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 Port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port i_start, input, 1 bit: level request that starts a burst.
REQ-008 Port i_stop, input, 1 bit: level request that aborts a burst.
REQ-009 Port i_burst_len, input, BURST_W bits: number of payload symbols in the burst.
REQ-010 Port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port o_done, output, 1 bit: one-clock pulse on the first IDLE cycle after FLUSH.
REQ-012 Port o_prbs_reset, output, 1 bit: active-high seed/reset to the PRBS I/Q generator.
REQ-013 Port o_prbs_enable, output, 1 bit: advances the PRBS one step.
REQ-014 Port o_sym_valid, output, 1 bit: symbol strobe for the upconverter.
REQ-015 Port o_phase, output, 3 bits: sample phase within the symbol, 0..OS_FACTOR-1.
REQ-016 Port o_preamble, output, 1 bit: marks the preamble symbols.

Function
REQ-017 States SHALL be IDLE, SEED, PREAMBLE, RUN, FLUSH, and all outputs SHALL be registered.
REQ-018 IDLE: i_start=1 with i_burst_len!=0 -> SEED next clock; i_burst_len=0 -> stay IDLE, no o_done.
REQ-019 IDLE: i_start and i_stop both high -> stay IDLE (stop wins).
REQ-020 i_start while o_busy=1 SHALL be ignored.
REQ-021 SEED lasts exactly one clock, with o_prbs_reset=1 and i_burst_len captured into the symbol counter.
REQ-022 SEED exits to PREAMBLE (macro defined) or RUN (macro undefined); i_stop is not sampled in SEED.
REQ-023 Phase counter: 0 on entry to PREAMBLE/RUN, +1 per clock, wraps OS_FACTOR-1 -> 0; it is held at 0 in IDLE, SEED and FLUSH.
REQ-024 o_sym_valid=1 when phase==0 in PREAMBLE or RUN; first strobe is 2 clocks after the i_start sample.
REQ-025 PREAMBLE: o_preamble=1 and o_prbs_enable=0; after PREAMBLE_LEN symbols, at phase OS_FACTOR-1 -> RUN.
REQ-026 RUN: o_prbs_enable=o_sym_valid; the symbol counter decrements on each strobe.
REQ-027 RUN -> FLUSH at phase OS_FACTOR-1 of the symbol in which the counter reached 0.
REQ-028 i_stop in PREAMBLE/RUN: finish the current symbol, then -> FLUSH at phase OS_FACTOR-1; no further strobes.
REQ-029 FLUSH: o_sym_valid=0 and o_prbs_enable=0 for FLUSH_CYC clocks, then -> IDLE with o_done=1 for one clock.
REQ-030 The symbol counter SHALL be BURST_W bits wide and SHALL NOT underflow; the maximum burst is 2^BURST_W-1 symbols.

Reset
REQ-031 i_reset=1 SHALL force state IDLE, phase 0 and counters 0 at the next edge, from any state, including mid-burst.
REQ-032 Reset values SHALL be: o_busy=0, o_done=0, o_sym_valid=0, o_prbs_enable=0, o_preamble=0, o_phase=0, o_prbs_reset=1.
REQ-033 o_prbs_reset SHALL return to 0 on the first clock after reset deasserts, so the PRBS is held in reset while the sequencer is.
REQ-034 A reset during a burst SHALL NOT generate o_done.

Configuration
REQ-035 Macro TX_SEQ_PREAMBLE_EN defined: the PREAMBLE state and PREAMBLE_LEN are present, and o_preamble is driven as in REQ-025.
REQ-036 Macro TX_SEQ_PREAMBLE_EN undefined: the PREAMBLE state is absent, SEED goes directly to RUN, and o_preamble is tied to 0.

Structure
REQ-037 Shared package tx_pkg SHALL hold the state enum type tx_seq_state_t and the constants PHASE_W=3 and the defaults of OS_FACTOR, PREAMBLE_LEN and FLUSH_CYC.
REQ-038 Sub-module sym_timer (phase counter plus strobe generation, enable/clear inputs) SHALL be instantiated once; the FSM and counters stay in tx_sequencer.

Verification (OS_FACTOR=4, FLUSH_CYC=8; cycle 0 = edge sampling i_start)
REQ-039 Macro on, PREAMBLE_LEN=8, burst 3 -> prbs_reset at cycle 1; preamble strobes at cycles 2,6,...,30; payload strobes at 34,38,42 with prbs_enable; FLUSH cycles 46-53; o_done at 54.
REQ-040 Macro off, burst 3 -> strobes at cycles 2,6,10; FLUSH cycles 14-21; o_done at 22; o_preamble never 1.
REQ-041 Macro off, burst 10, i_stop pulsed at cycle 8 -> strobes at 2,6 only; FLUSH from cycle 10; o_done at 18.
REQ-042 i_burst_len=0 with i_start -> o_busy stays 0 and no strobes; i_start+i_stop together -> stays IDLE.
REQ-043 i_reset at cycle 20 of a 10-symbol burst -> next clock: all outputs at reset values, o_done never pulses; a subsequent start restarts normally.
REQ-044 i_burst_len=16'hFFFF -> exactly 65535 payload strobes, then FLUSH and o_done, with no wrap of the counter.
